// File: rtl/fp_int_acc_seq_if.sv
// Beat/result handshake bundle for the block-floating-point accumulator.
// The master side drives beats and consumes results; the slave side is the accumulator.
interface fp_int_acc_seq_if #(
    parameter int EXP_W = 5,
    parameter int IN_W  = 14,
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_first;
    logic             in_last;
    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [IN_W-1:0]  in_mag;

    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [EXP_W-1:0] out_exp;
    logic             out_ovf;
    logic [CNT_W-1:0] out_cnt;

    modport master (
        output in_valid, in_first, in_last, in_sign, in_exp, in_mag, out_ready,
        input  in_ready, out_valid, out_acc, out_exp, out_ovf, out_cnt
    );

    modport slave (
        input  in_valid, in_first, in_last, in_sign, in_exp, in_mag, out_ready,
        output in_ready, out_valid, out_acc, out_exp, out_ovf, out_cnt
    );
endinterface

// File: rtl/fp_int_acc_seq.sv
// Block-floating-point accumulator: aligns each sign/magnitude/exponent beat to the running
// sum at the smaller exponent, adds with saturation, and reports one result per group.
module fp_int_acc_seq #(
    parameter int EXP_W = 5,
    parameter int IN_W  = 14,
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
) (
    input logic            clk,
    input logic            rst,
    fp_int_acc_seq_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ALIGN, ADD, OUT} state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Left shift that clamps to the signed range instead of dropping bits or flipping sign.
    function automatic logic signed [ACC_W-1:0] shl_sat(
        input  logic signed [ACC_W-1:0] v,
        input  logic        [EXP_W-1:0] sh,
        output logic                    sat
    );
        logic signed [ACC_W-1:0] shifted;
        shifted = v <<< sh;
        sat     = 1'b0;
        if (v == '0) begin
            shl_sat = '0;
        end else if (int'(sh) >= ACC_W || (shifted >>> sh) != v) begin
            sat     = 1'b1;
            shl_sat = v[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end else begin
            shl_sat = shifted;
        end
    endfunction

    state_t                  state_q,      state_d;
    logic                    beat_first_q, beat_first_d;
    logic                    beat_last_q,  beat_last_d;
    logic                    beat_sign_q,  beat_sign_d;
    logic        [EXP_W-1:0] beat_exp_q,   beat_exp_d;
    logic        [IN_W-1:0]  beat_mag_q,   beat_mag_d;
    logic signed [ACC_W-1:0] a_al_q,       a_al_d;
    logic signed [ACC_W-1:0] m_al_q,       m_al_d;
    logic        [EXP_W-1:0] r_exp_q,      r_exp_d;
    logic                    shf_sat_q,    shf_sat_d;
    logic signed [ACC_W-1:0] acc_q,        acc_d;
    logic        [EXP_W-1:0] exp_q,        exp_d;
    logic                    ovf_q,        ovf_d;
    logic        [CNT_W-1:0] cnt_q,        cnt_d;

    logic signed [ACC_W-1:0] a_base;
    logic signed [ACC_W-1:0] mag_ext;
    logic signed [ACC_W-1:0] m_val;
    logic        [EXP_W-1:0] ea;
    logic                    a_sat;
    logic                    m_sat;
    logic signed [ACC_W:0]   sum_wide;
    logic                    add_sat;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d      = state_q;
        beat_first_d = beat_first_q;
        beat_last_d  = beat_last_q;
        beat_sign_d  = beat_sign_q;
        beat_exp_d   = beat_exp_q;
        beat_mag_d   = beat_mag_q;
        a_al_d       = a_al_q;
        m_al_d       = m_al_q;
        r_exp_d      = r_exp_q;
        shf_sat_d    = shf_sat_q;
        acc_d        = acc_q;
        exp_d        = exp_q;
        ovf_d        = ovf_q;
        cnt_d        = cnt_q;
        a_base       = beat_first_q ? '0 : acc_q;
        mag_ext      = {{(ACC_W-IN_W){1'b0}}, beat_mag_q};
        m_val        = beat_sign_q ? -mag_ext : mag_ext;
        ea           = '0;
        a_sat        = 1'b0;
        m_sat        = 1'b0;
        sum_wide     = '0;
        add_sat      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    beat_first_d = bus.in_first;
                    beat_last_d  = bus.in_last;
                    beat_sign_d  = bus.in_sign;
                    beat_exp_d   = bus.in_exp;
                    beat_mag_d   = bus.in_mag;
                    state_d      = ALIGN;
                end
            end

            ALIGN: begin
                if (!beat_first_q && beat_mag_q == '0) begin
                    // A zero contribution must not drag the sum to a finer exponent.
                    a_al_d    = acc_q;
                    m_al_d    = '0;
                    r_exp_d   = exp_q;
                    shf_sat_d = 1'b0;
                end else begin
                    ea = (beat_first_q || acc_q == '0) ? beat_exp_q : exp_q;
                    if (ea > beat_exp_q) begin
                        a_al_d  = shl_sat(a_base, ea - beat_exp_q, a_sat);
                        m_al_d  = m_val;
                        r_exp_d = beat_exp_q;
                    end else begin
                        a_al_d  = a_base;
                        m_al_d  = shl_sat(m_val, beat_exp_q - ea, m_sat);
                        r_exp_d = ea;
                    end
                    shf_sat_d = a_sat | m_sat;
                end
                state_d = ADD;
            end

            ADD: begin
                sum_wide = {a_al_q[ACC_W-1], a_al_q} + {m_al_q[ACC_W-1], m_al_q};
                add_sat  = sum_wide[ACC_W] != sum_wide[ACC_W-1];
                if (add_sat) begin
                    acc_d = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
                end else begin
                    acc_d = sum_wide[ACC_W-1:0];
                end
                exp_d = r_exp_q;
                if (beat_first_q) begin
                    cnt_d = CNT_W'(1);
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                ovf_d   = (beat_first_q ? 1'b0 : ovf_q) | shf_sat_q | add_sat;
                state_d = beat_last_q ? OUT : IDLE;
            end

            OUT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            beat_first_q <= 1'b0;
            beat_last_q  <= 1'b0;
            beat_sign_q  <= 1'b0;
            beat_exp_q   <= '0;
            beat_mag_q   <= '0;
            a_al_q       <= '0;
            m_al_q       <= '0;
            r_exp_q      <= '0;
            shf_sat_q    <= 1'b0;
            acc_q        <= '0;
            exp_q        <= '0;
            ovf_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the values from before this edge.
            state_q      <= state_d;
            beat_first_q <= beat_first_d;
            beat_last_q  <= beat_last_d;
            beat_sign_q  <= beat_sign_d;
            beat_exp_q   <= beat_exp_d;
            beat_mag_q   <= beat_mag_d;
            a_al_q       <= a_al_d;
            m_al_q       <= m_al_d;
            r_exp_q      <= r_exp_d;
            shf_sat_q    <= shf_sat_d;
            acc_q        <= acc_d;
            exp_q        <= exp_d;
            ovf_q        <= ovf_d;
            cnt_q        <= cnt_d;
        end
    end

    // Ready is gated by reset so the upstream sees no acceptance window while held in reset.
    assign bus.in_ready  = (state_q == IDLE) && rst;
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_acc   = acc_q;
    assign bus.out_exp   = exp_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_cnt   = cnt_q;

    a_out_hold: assert property (@(posedge clk) disable iff (!rst)
        bus.out_valid && !bus.out_ready |=> bus.out_valid && $stable(bus.out_acc) && $stable(bus.out_exp));

    a_ready_excl: assert property (@(posedge clk) disable iff (!rst)
        !(bus.in_ready && bus.out_valid));

endmodule

// File: tb/tb_fp_int_acc_seq.sv
// Self-checking bench for fp_int_acc_seq: a wide-integer reference model pushes expected
// group results into a queue as beats are driven; results are popped when out_valid appears.
module tb_fp_int_acc_seq;

    localparam int EXP_W = 5;
    localparam int IN_W  = 14;
    localparam int ACC_W = 32;
    localparam int CNT_W = 8;
    localparam longint ACC_MAX = (64'sd1 <<< (ACC_W-1)) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< (ACC_W-1));
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic [EXP_W-1:0] ex;
        logic             ovf;
        logic [CNT_W-1:0] cnt;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_int_acc_seq_if #(.EXP_W(EXP_W), .IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    fp_int_acc_seq #(.EXP_W(EXP_W), .IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    res_t   sb_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    longint m_acc;
    int     m_exp;
    bit     m_ovf;
    int     m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic longint clampv(input longint v, output bit hit);
        hit = 1'b0;
        if (v > ACC_MAX) begin
            hit = 1'b1;
            return ACC_MAX;
        end
        if (v < ACC_MIN) begin
            hit = 1'b1;
            return ACC_MIN;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_acc = 0;
        m_exp = 0;
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_beat(input bit first, input bit last, input bit sign, input int e, input int mag);
        longint a, m, s;
        int     ea, r;
        bit     h1, h2, h3;
        res_t   res;
        if (first) begin
            m_ovf = 1'b0;
            m_cnt = 1;
        end else if (m_cnt < CNT_MAX) begin
            m_cnt++;
        end
        if (first || mag != 0) begin
            a  = first ? 0 : m_acc;
            ea = (first || m_acc == 0) ? e : m_exp;
            r  = (ea < e) ? ea : e;
            a  = clampv(a <<< (ea - r), h1);
            m  = sign ? -longint'(mag) : longint'(mag);
            m  = clampv(m <<< (e - r), h2);
            s  = clampv(a + m, h3);
            m_acc = s;
            m_exp = r;
            if (h1 || h2 || h3) m_ovf = 1'b1;
        end
        if (last) begin
            res.acc = m_acc[ACC_W-1:0];
            res.ex  = m_exp[EXP_W-1:0];
            res.ovf = m_ovf;
            res.cnt = m_cnt[CNT_W-1:0];
            sb_q.push_back(res);
        end
    endtask

    // Waits for an accept slot, drives one beat for a single edge, and updates the model.
    task automatic send_beat(input bit first, input bit last, input bit sign, input int e, input int mag);
        int waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", bus.in_ready, 1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_first = first;
        bus.in_last  = last;
        bus.in_sign  = sign;
        bus.in_exp   = EXP_W'(e);
        bus.in_mag   = IN_W'(mag);
        @(negedge clk);
        bus.in_valid = 1'b0;
        model_beat(first, last, sign, e, mag);
    endtask

    task automatic wait_valid(input string tag);
        int waited = 0;
        while (!bus.out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"}, bus.out_valid, 1);
    endtask

    task automatic collect(input string tag);
        res_t want;
        wait_valid(tag);
        if (bus.out_valid && sb_q.size() != 0) begin
            want = sb_q.pop_front();
            check({tag, "_acc"}, bus.out_acc, want.acc);
            check({tag, "_exp"}, bus.out_exp, want.ex);
            check({tag, "_ovf"}, bus.out_ovf, want.ovf);
            check({tag, "_cnt"}, bus.out_cnt, want.cnt);
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            check({tag, "_released"}, bus.out_valid, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [ACC_W-1:0] held_acc;
        logic [EXP_W-1:0] held_exp;

        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mag    = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_in_ready",  bus.in_ready,  0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_acc",   bus.out_acc,   0);
        check("rst_out_cnt",   bus.out_cnt,   0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1);

        // T1: single-beat group with result two edges after acceptance.
        bus.out_ready = 1'b1;
        send_beat(1, 1, 0, 3, 100);
        check("t1_lat0", bus.out_valid, 0);
        @(negedge clk);
        check("t1_lat1", bus.out_valid, 0);
        @(negedge clk);
        check("t1_lat2", bus.out_valid, 1);
        collect("t1");
        check("t1_acc_const", bus.out_acc, 100);

        // T2: alignment in both directions; out_ready held high outside OUT has no effect.
        bus.out_ready = 1'b1;
        send_beat(1, 0, 0, 3, 100);
        send_beat(0, 0, 0, 5, 5);
        repeat (2) @(negedge clk);
        check("t2_mid_valid", bus.out_valid, 0);
        check("t2_mid_acc",   bus.out_acc,   120);
        check("t2_mid_exp",   bus.out_exp,   3);
        bus.out_ready = 1'b0;
        send_beat(0, 1, 1, 1, 1);
        collect("t2");
        check("t2_acc_const", bus.out_acc, 479);

        // T3: shift saturation, then a fresh group clears the sticky flag.
        send_beat(1, 0, 0, 20, 16383);
        send_beat(0, 1, 0, 0, 1);
        collect("t3");
        check("t3_acc_const", bus.out_acc, 32'h7FFF_FFFF);
        send_beat(1, 1, 0, 2, 9);
        collect("t3_next");

        // T4: back-pressure holds the result; beats offered meanwhile are ignored.
        send_beat(1, 1, 1, 7, 250);
        wait_valid("t4_pre");
        held_acc = sb_q[0].acc;
        held_exp = sb_q[0].ex;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_first = 1'b1;
            bus.in_last  = 1'b1;
            bus.in_mag   = IN_W'(999);
            bus.in_exp   = EXP_W'(1);
            @(negedge clk);
            check("t4_hold_valid", bus.out_valid, 1);
            check("t4_hold_ready", bus.in_ready,  0);
            check("t4_hold_acc",   bus.out_acc,   held_acc);
            check("t4_hold_exp",   bus.out_exp,   held_exp);
        end
        bus.in_valid = 1'b0;
        collect("t4");
        check("t4_idle_ready", bus.in_ready, 1);
        repeat (2) @(negedge clk);
        check("t4_nocap_acc",   bus.out_acc,  held_acc);
        check("t4_nocap_ready", bus.in_ready, 1);

        // T6: zero and negative beats.
        send_beat(1, 0, 0, 0, 0);
        send_beat(0, 0, 1, 6, 3);
        send_beat(0, 1, 0, 0, 0);
        collect("t6");
        check("t6_acc_const", bus.out_acc, 32'hFFFF_FFFD);
        check("t6_exp_const", bus.out_exp, 6);

        // T5: reset while the beat is in ALIGN discards it and clears all outputs.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_first = 1'b1;
        bus.in_last  = 1'b1;
        bus.in_sign  = 1'b0;
        bus.in_exp   = EXP_W'(2);
        bus.in_mag   = IN_W'(50);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("t5_rst_valid", bus.out_valid, 0);
        check("t5_rst_ready", bus.in_ready,  0);
        check("t5_rst_acc",   bus.out_acc,   0);
        check("t5_rst_exp",   bus.out_exp,   0);
        check("t5_rst_ovf",   bus.out_ovf,   0);
        check("t5_rst_cnt",   bus.out_cnt,   0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        send_beat(0, 1, 0, 4, 7);
        collect("t5");

        // Counter saturation on a long group.
        send_beat(1, 0, 0, 0, 1);
        for (int i = 0; i < 298; i++) send_beat(0, 0, 0, 0, 1);
        send_beat(0, 1, 0, 0, 1);
        collect("cnt_sat");
        check("cnt_sat_const", bus.out_cnt, CNT_MAX);

        // Random groups against the reference model.
        for (int g = 0; g < 8; g++) begin
            int len;
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) begin
                send_beat(b == 0, b == len - 1, 1'($urandom_range(0, 1)),
                          $urandom_range(0, (1 << EXP_W) - 1),
                          ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, (1 << IN_W) - 1));
            end
            collect("rand");
        end

        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
